axi_wr_slave_buf: RTL
=====================

# axi_wr_slave_buf

AXI3 write-channel slave with buffering. It accepts one write burst at a time (AW, then W beats), stores beats in a parametrised FIFO, and forwards each beat to the attached device over a valid/ready port with a generated per-beat address. It returns a single B response per burst. It sits between the interconnect's write channels and a memory-like device, and is the parametrised successor to the single-beat `writefinish`-based write slave.

## Interface
- `DATA_W`, 32: W data width in bits; power of two, 8 to 256.
- `ADDR_W`, 32: address width in bits.
- `ID_W`, 4: AWID/WID/BID width in bits.
- `FIFO_DEPTH`, 4: write-data FIFO entries; power of two, 2 or more.
- `ACLK` in 1: clock; all logic on rising edge.
- `ARESETn` in 1: synchronous, active-low reset.
- `AWID` in ID_W: burst ID.
- `AWADDR` in ADDR_W: start address.
- `AWLEN` in 4: beats minus 1.
- `AWSIZE` in 3: log2 of bytes per beat.
- `AWBURST` in 2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `AWVALID` in 1 / `AWREADY` out 1: AW handshake.
- `WDATA` in DATA_W, `WSTRB` in DATA_W/8, `WLAST` in 1: write beat.
- `WVALID` in 1 / `WREADY` out 1: W handshake.
- `BID` out ID_W, `BRESP` out 2: response; 00 OKAY, 10 SLVERR.
- `BVALID` out 1 / `BREADY` in 1: B handshake.
- `dev_addr` out ADDR_W, `dev_data` out DATA_W, `dev_strb` out DATA_W/8: beat to the device.
- `dev_valid` out 1 / `dev_ready` in 1: device handshake; a beat transfers when both are 1.

## Operation
- States are IDLE, DATA and RESP.
- **IDLE**
  - AWREADY=1.
  - On the AW handshake, register ID, ADDR, LEN, SIZE and BURST; clear the beat counter and error flag; go to DATA.
- **AW checks.** The error flag is set at AW capture if any of these hold:
  - AWSIZE > log2(DATA_W/8).
  - AWBURST=11.
  - WRAP with AWLEN not in {1,3,7,15}.
  - WRAP with AWADDR not aligned to 2^AWSIZE.
- **DATA**
  - WREADY = !fifo_full && !w_done.
  - Each W handshake increments the beat counter.
  - The beat is pushed to the FIFO only if the error flag was clear at AW capture. Otherwise it is accepted and discarded.
  - WLAST with counter < LEN: set the error flag; burst input ends (w_done=1).
  - Counter reaches LEN without WLAST: set the error flag. Keep accepting and discarding beats until WLAST.
  - WID is ignored.
- **Device side**
  - dev_valid = !fifo_empty.
  - Head entry drives dev_data and dev_strb; dev_addr is the current beat address.
  - Each dev handshake pops the FIFO and advances the address.
- **Address update** (registered, ADDR_W bits, wraps modulo 2^ADDR_W):
  - FIXED: unchanged.
  - INCR: addr + (1<<SIZE).
  - WRAP: with wrap size W = (LEN+1)<<SIZE, addr = (addr & ~(W-1)) | ((addr + (1<<SIZE)) & (W-1)).
- **DATA to RESP** when w_done and the FIFO is empty.
- **RESP**
  - BVALID=1, BID=captured ID, BRESP = error flag ? 10 : 00.
  - On the B handshake, go to IDLE.
- Only one burst is in flight. AWREADY=0 outside IDLE.

## Timing
- **Reset values:** AWREADY=0 while ARESETn=0, and 1 on the first cycle after release (IDLE). WREADY=0, BVALID=0, BRESP=00, BID=0, dev_valid=0, dev_addr=0, dev_data=0, dev_strb=0.
- **Reset mid-burst:** the FIFO is emptied, the burst is abandoned, and no B response is issued.
- All outputs are registered or decoded from state and FIFO flags only. No combinational path from any input to any output.
- AW handshake in cycle N: WREADY can be 1 in N+1.
- W beat pushed in cycle N: dev_valid=1 with that beat in N+1.
- Last dev pop in cycle N: BVALID=1 in N+1.
- **Full FIFO:** a push and pop in the same cycle with the FIFO full is not allowed (WREADY=0 when full). With the FIFO empty, a push and pop in the same cycle cannot occur.
- Throughput is 1 beat per cycle when dev_ready is held at 1.
- BVALID and BRESP stay stable until BREADY. dev_* stay stable while dev_valid && !dev_ready.

## Configuration
- **`AXI_WR_WRAP_EN` defined:** WRAP bursts are supported as specified above.
- **`AXI_WR_WRAP_EN` undefined:** AWBURST=10 is treated as reserved. The error flag is set, beats are accepted and discarded, and BRESP=10. The wrap-address logic is not compiled.

## Test plan
- **INCR burst.** AWADDR=0x100, AWLEN=3, AWSIZE=2, dev_ready=1. Expect dev_addr 0x100, 0x104, 0x108, 0x10C; then BVALID with BID=AWID and BRESP=00.
- **Backpressure.** Same INCR burst with dev_ready=0 for 10 cycles. Expect WREADY to drop after 4 accepted beats (FIFO full). Release dev_ready: all 4 beats are delivered in order and BRESP=00.
- **WRAP** (macro defined). AWADDR=0x38, AWLEN=3, AWSIZE=2. Expect dev_addr 0x38, 0x3C, 0x30, 0x34.
- **Early WLAST.** AWLEN=3 with WLAST on beat 2. Expect 2 dev beats, then BRESP=10.
- **Bad size.** AWSIZE=3 with DATA_W=32. Expect the beats accepted, no dev_valid, and BRESP=10. WRAP with the macro undefined also gives BRESP=10.
- **Reset mid-burst.** Assert ARESETn=0 after 2 of 4 beats. Expect the FIFO empty, no BVALID, AWREADY=1 after release, and the next burst completing with OKAY.

Source files
------------

// File: rtl/axi_wr_slave_buf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : axi_wr_slave_buf                                            |
// | Purpose  : AXI3 write slave. Takes one burst at a time (AW then W),    |
// |            buffers beats in a FIFO, forwards each beat to a device     |
// |            with a generated per-beat address, returns one B response.  |
// | Options  : AXI_WR_WRAP_EN - enables WRAP bursts; when undefined WRAP   |
// |            is rejected like the reserved burst type.                   |
// | Revision : 1.0 - initial parametrised release                          |
// +------------------------------------------------------------------------+
module axi_wr_slave_buf #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [ADDR_W-1:0]   dev_addr,
  output logic [DATA_W-1:0]   dev_data,
  output logic [DATA_W/8-1:0] dev_strb,
  output logic                dev_valid,
  input  logic                dev_ready
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int MAX_SIZE = $clog2(STRB_W);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                awready_q, awready_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [3:0]          beat_q, beat_d;
  logic                err_q, err_d;       // reported in BRESP
  logic                drop_q, drop_d;     // burst rejected at AW: discard beats
  logic                over_q, over_d;     // beat LEN went by without WLAST
  logic                w_done_q, w_done_d;

  logic [DATA_W-1:0]   data_mem_q [FIFO_DEPTH];
  logic [STRB_W-1:0]   strb_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                fifo_full, fifo_empty;
  logic                aw_hs, w_hs, dev_hs, push;
  logic                wready_int;
  logic                aw_err;
  logic [ADDR_W-1:0]   addr_step, addr_adv, addr_next;
`ifdef AXI_WR_WRAP_EN
  logic [ADDR_W-1:0]   wrap_mask;
`endif

  // Legality checks on the incoming AW request.
  always_comb begin
    aw_err = 1'b0;
    if (AWSIZE > 3'(MAX_SIZE)) aw_err = 1'b1;
    if (AWBURST == BURST_RSVD) aw_err = 1'b1;
`ifdef AXI_WR_WRAP_EN
    if (AWBURST == BURST_WRAP) begin
      if (AWLEN != 4'd1 && AWLEN != 4'd3 && AWLEN != 4'd7 && AWLEN != 4'd15) aw_err = 1'b1;
      if ((AWADDR & ((ADDR_W'(1) << AWSIZE) - ADDR_W'(1))) != '0) aw_err = 1'b1;
    end
`else
    if (AWBURST == BURST_WRAP) aw_err = 1'b1;
`endif
  end

  // Handshakes and FIFO occupancy/pointer update.
  always_comb begin
    fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    fifo_empty = (cnt_q == '0);
    aw_hs      = awready_q && AWVALID;
    wready_int = (state_q == S_DATA) && !fifo_full && !w_done_q;
    w_hs       = WVALID && wready_int;
    dev_hs     = !fifo_empty && dev_ready;
    // Beats beyond LEN and beats of a rejected burst are swallowed.
    push       = w_hs && !drop_q && !over_q;
    wptr_d     = push   ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d     = dev_hs ? rptr_q + PTR_W'(1) : rptr_q;
    cnt_d      = cnt_q;
    if (push && !dev_hs) cnt_d = cnt_q + CNT_W'(1);
    if (!push && dev_hs) cnt_d = cnt_q - CNT_W'(1);
  end

  // Address of the beat after the one currently at the FIFO head.
  always_comb begin
    addr_step = ADDR_W'(1) << size_q;
    addr_adv  = addr_q + addr_step;
    addr_next = addr_adv;
`ifdef AXI_WR_WRAP_EN
    wrap_mask = (ADDR_W'({1'b0, len_q} + 5'd1) << size_q) - ADDR_W'(1);
`endif
    if (burst_q == BURST_FIXED) begin
      addr_next = addr_q;
    end
`ifdef AXI_WR_WRAP_EN
    else if (burst_q == BURST_WRAP) begin
      addr_next = (addr_q & ~wrap_mask) | (addr_adv & wrap_mask);
    end
`endif
  end

  // Burst FSM: capture AW, track W beats and protocol errors, issue B.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = dev_hs ? addr_next : addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    err_d    = err_q;
    drop_d   = drop_q;
    over_d   = over_q;
    w_done_d = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          id_d     = AWID;
          addr_d   = AWADDR;
          len_d    = AWLEN;
          size_d   = AWSIZE;
          burst_d  = AWBURST;
          beat_d   = 4'd0;
          err_d    = aw_err;
          drop_d   = aw_err;
          over_d   = 1'b0;
          w_done_d = 1'b0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 4'd1;
          if (WLAST) begin
            w_done_d = 1'b1;
            if (!over_q && beat_q < len_q) err_d = 1'b1;
          end else if (!over_q && beat_q == len_q) begin
            over_d = 1'b1;
            err_d  = 1'b1;
          end
        end
        // Leave once input is complete and the last beat leaves this cycle.
        if (w_done_d && cnt_d == '0) state_d = S_RESP;
      end
      S_RESP: begin
        if (BREADY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    awready_d = (state_d == S_IDLE);
  end

  // Control and FIFO bookkeeping registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
      over_q    <= 1'b0;
      w_done_q  <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
      over_q    <= over_d;
      w_done_q  <= w_done_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // FIFO storage; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge ACLK) begin
    if (push) begin
      data_mem_q[wptr_q] <= WDATA;
      strb_mem_q[wptr_q] <= WSTRB;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_int;
  assign BVALID    = (state_q == S_RESP);
  assign BID       = id_q;
  assign BRESP     = ((state_q == S_RESP) && err_q) ? 2'b10 : 2'b00;
  assign dev_valid = !fifo_empty;
  assign dev_addr  = addr_q;
  assign dev_data  = fifo_empty ? '0 : data_mem_q[rptr_q];
  assign dev_strb  = fifo_empty ? '0 : strb_mem_q[rptr_q];

endmodule
`default_nettype wire
